// File: rtl/mem_arbiter_if.sv
// Requester, RAM and status signals of the two-port RAM arbiter.
// slave is the arbiter's view; master is the view of whatever drives the requests and the RAM.
interface mem_arbiter_if;
    logic        req0;
    logic        req1;
    logic        we0;
    logic        we1;
    logic [15:0] addr0;
    logic [15:0] addr1;
    logic [15:0] wdata0;
    logic [15:0] wdata1;
    logic        gnt0;
    logic        gnt1;
    logic        done0;
    logic        done1;
    logic [15:0] rdata0;
    logic [15:0] rdata1;
    logic [15:0] ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic        ram_rd;
    logic        ram_wr;
    logic        busy;
    logic [1:0]  stateout;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
        output gnt0, gnt1, done0, done1, rdata0, rdata1,
        output ram_addr, ram_wdata, ram_rd, ram_wr, busy, stateout
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
        input  gnt0, gnt1, done0, done1, rdata0, rdata1,
        input  ram_addr, ram_wdata, ram_rd, ram_wr, busy, stateout
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving two requesters exclusive single-word RAM access.
// Request to done takes WAIT_CYCLES+1 edges; a losing or late requester simply waits, reqN held high.
module mem_arbiter #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic          clock,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    localparam logic [3:0] WAIT_EFF = (WAIT_CYCLES == 0) ? 4'd1 : 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        DONE    = 2'd2,
        ILLEGAL = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        owner;
    logic        last;
    logic [3:0]  cnt;
    logic        we_l;
    logic [15:0] addr_l;
    logic [15:0] wdata_l;
    logic        gnt0_q;
    logic        gnt1_q;
    logic [15:0] rdata0_q;
    logic [15:0] rdata1_q;
    logic        any_req;
    logic        pick;
    logic        access_end;

    // On contention the port that did not win last time goes first.
    always_comb begin
        any_req    = bus.req0 | bus.req1;
        pick       = (bus.req0 & bus.req1) ? ~last : bus.req1;
        access_end = (cnt == WAIT_EFF);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ACCESS;
            ACCESS:  if (access_end) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            owner    <= 1'b0;
            last     <= 1'b1;
            cnt      <= 4'd0;
            we_l     <= 1'b0;
            addr_l   <= 16'd0;
            wdata_l  <= 16'd0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            rdata0_q <= 16'd0;
            rdata1_q <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner   <= pick;
                        last    <= pick;
                        cnt     <= 4'd1;
                        we_l    <= pick ? bus.we1    : bus.we0;
                        addr_l  <= pick ? bus.addr1  : bus.addr0;
                        wdata_l <= pick ? bus.wdata1 : bus.wdata0;
                        gnt0_q  <= ~pick;
                        gnt1_q  <= pick;
                    end
                end
                ACCESS: begin
                    cnt <= cnt + 4'd1;
                    // Read data is taken on the edge that leaves ACCESS, while ram_rd is still high.
                    if (access_end && !we_l) begin
                        if (owner) rdata1_q <= bus.ram_rdata;
                        else       rdata0_q <= bus.ram_rdata;
                    end
                end
                default: begin
                    gnt0_q <= 1'b0;
                    gnt1_q <= 1'b0;
                end
            endcase
        end
    end

    // RAM strobes come only from the state register and latched request, so reset cuts them off at once.
    assign bus.ram_rd    = (state == ACCESS) & ~we_l;
    assign bus.ram_wr    = (state == ACCESS) &  we_l;
    assign bus.ram_addr  = addr_l;
    assign bus.ram_wdata = wdata_l;
    assign bus.gnt0      = gnt0_q;
    assign bus.gnt1      = gnt1_q;
    assign bus.done0     = (state == DONE) & ~owner;
    assign bus.done1     = (state == DONE) &  owner;
    assign bus.rdata0    = rdata0_q;
    assign bus.rdata1    = rdata1_q;
    assign bus.busy      = (state != IDLE);
    assign bus.stateout  = state;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance 0 runs with WAIT_CYCLES=1, instance 1 with WAIT_CYCLES=3.
// A transaction-level model (owner + cycles since grant) predicts every output on every cycle.
module tb_mem_arbiter;
    typedef struct packed {
        logic        req0;
        logic        req1;
        logic        we0;
        logic        we1;
        logic [15:0] addr0;
        logic [15:0] addr1;
        logic [15:0] wdata0;
        logic [15:0] wdata1;
    } stim_t;

    typedef struct packed {
        logic        gnt0;
        logic        gnt1;
        logic        done0;
        logic        done1;
        logic [15:0] rdata0;
        logic [15:0] rdata1;
        logic [15:0] ram_addr;
        logic [15:0] ram_wdata;
        logic        ram_rd;
        logic        ram_wr;
        logic        busy;
        logic [1:0]  stateout;
    } obs_t;

    logic  clock;
    logic  reset;
    stim_t stim [2];
    obs_t  obs  [2];

    int total = 0;
    int bad   = 0;

    // Model state per instance.
    int          owner [2];
    int          age   [2];
    int          last  [2];
    bit          fresh [2];
    logic        lwe   [2];
    logic [15:0] laddr [2];
    logic [15:0] lwdat [2];
    logic [15:0] rdm   [2][2];

    mem_arbiter_if bus_a ();
    mem_arbiter_if bus_b ();

    mem_arbiter #(.WAIT_CYCLES(1)) dut_a (.clock(clock), .reset(reset), .bus(bus_a.slave));
    mem_arbiter #(.WAIT_CYCLES(3)) dut_b (.clock(clock), .reset(reset), .bus(bus_b.slave));

    function automatic logic [15:0] ram_f(input logic [15:0] a);
        if (a == 16'h0010) return 16'hBEEF;
        return {a[7:0], a[15:8]} ^ 16'h5A5A;
    endfunction

    function automatic int wv(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    assign bus_a.req0 = stim[0].req0;   assign bus_b.req0 = stim[1].req0;
    assign bus_a.req1 = stim[0].req1;   assign bus_b.req1 = stim[1].req1;
    assign bus_a.we0  = stim[0].we0;    assign bus_b.we0  = stim[1].we0;
    assign bus_a.we1  = stim[0].we1;    assign bus_b.we1  = stim[1].we1;
    assign bus_a.addr0  = stim[0].addr0;  assign bus_b.addr0  = stim[1].addr0;
    assign bus_a.addr1  = stim[0].addr1;  assign bus_b.addr1  = stim[1].addr1;
    assign bus_a.wdata0 = stim[0].wdata0; assign bus_b.wdata0 = stim[1].wdata0;
    assign bus_a.wdata1 = stim[0].wdata1; assign bus_b.wdata1 = stim[1].wdata1;
    assign bus_a.ram_rdata = ram_f(bus_a.ram_addr);
    assign bus_b.ram_rdata = ram_f(bus_b.ram_addr);

    assign obs[0] = {bus_a.gnt0, bus_a.gnt1, bus_a.done0, bus_a.done1, bus_a.rdata0, bus_a.rdata1,
                     bus_a.ram_addr, bus_a.ram_wdata, bus_a.ram_rd, bus_a.ram_wr, bus_a.busy, bus_a.stateout};
    assign obs[1] = {bus_b.gnt0, bus_b.gnt1, bus_b.done0, bus_b.done1, bus_b.rdata0, bus_b.rdata1,
                     bus_b.ram_addr, bus_b.ram_wdata, bus_b.ram_rd, bus_b.ram_wr, bus_b.busy, bus_b.stateout};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic cmp(input string nm, input int k, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst%0d at %0t: got=%h want=%h", nm, k, $time, act, exp);
        end
    endtask

    task automatic model_reset(input int k);
        owner[k] = -1;
        age[k]   = 0;
        last[k]  = 1;
        fresh[k] = 1'b1;
        lwe[k]   = 1'b0;
        laddr[k] = 16'd0;
        lwdat[k] = 16'd0;
        rdm[k][0] = 16'd0;
        rdm[k][1] = 16'd0;
    endtask

    task automatic model_edge(input int k);
        stim_t s;
        int w;
        int p;
        s = stim[k];
        w = wv(k);
        if (reset) begin
            model_reset(k);
        end else if (owner[k] < 0) begin
            if (s.req0 || s.req1) begin
                p = (s.req0 && s.req1) ? 1 - last[k] : (s.req0 ? 0 : 1);
                owner[k] = p;
                last[k]  = p;
                age[k]   = 1;
                fresh[k] = 1'b0;
                lwe[k]   = (p == 1) ? s.we1 : s.we0;
                laddr[k] = (p == 1) ? s.addr1 : s.addr0;
                lwdat[k] = (p == 1) ? s.wdata1 : s.wdata0;
            end
        end else if (age[k] == w + 1) begin
            owner[k] = -1;
        end else begin
            if (age[k] == w && !lwe[k]) rdm[k][owner[k]] = ram_f(laddr[k]);
            age[k]++;
        end
    endtask

    task automatic compare_all(input int k);
        obs_t o;
        bit act, acc, dn;
        logic [1:0] st;
        o   = obs[k];
        act = owner[k] >= 0;
        acc = act && age[k] <= wv(k);
        dn  = act && age[k] == wv(k) + 1;
        st  = !act ? 2'd0 : (acc ? 2'd1 : 2'd2);
        cmp("gnt0", k, o.gnt0, act && owner[k] == 0);
        cmp("gnt1", k, o.gnt1, act && owner[k] == 1);
        cmp("done0", k, o.done0, dn && owner[k] == 0);
        cmp("done1", k, o.done1, dn && owner[k] == 1);
        cmp("rdata0", k, o.rdata0, rdm[k][0]);
        cmp("rdata1", k, o.rdata1, rdm[k][1]);
        cmp("ram_rd", k, o.ram_rd, acc && !lwe[k]);
        cmp("ram_wr", k, o.ram_wr, acc && lwe[k]);
        cmp("busy", k, o.busy, act);
        cmp("stateout", k, o.stateout, st);
        cmp("gnt_excl", k, o.gnt0 & o.gnt1, 1'b0);
        if (acc || fresh[k]) begin
            cmp("ram_addr", k, o.ram_addr, laddr[k]);
            cmp("ram_wdata", k, o.ram_wdata, lwdat[k]);
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_edge(0);
        model_edge(1);
        #1;
        compare_all(0);
        compare_all(1);
    endtask

    // Called just after step(); asserts reset mid-cycle and checks outputs drop immediately.
    task automatic async_reset();
        #2;
        reset = 1'b1;
        #1;
        model_reset(0);
        model_reset(1);
        compare_all(0);
        compare_all(1);
    endtask

    initial begin
        int wr_n, done_at, n_gnt, n_done, prev_done;
        bit done_seen;
        logic [1:0] prev_st;
        int gseq [4];

        reset = 1'b1;
        stim[0] = '0;
        stim[1] = '0;
        #3;
        model_reset(0);
        model_reset(1);
        compare_all(0);
        compare_all(1);
        for (int k = 0; k < 2; k++) begin
            cmp("rst_stateout", k, obs[k].stateout, 2'd0);
            cmp("rst_busy", k, obs[k].busy, 1'b0);
            cmp("rst_rdata0", k, obs[k].rdata0, 16'h0000);
            cmp("rst_ram_addr", k, obs[k].ram_addr, 16'h0000);
        end
        step();
        step();
        reset = 1'b0;

        // Single read on the WAIT_CYCLES=1 instance.
        stim[0].req0 = 1'b1; stim[0].we0 = 1'b0; stim[0].addr0 = 16'h0010;
        step();
        cmp("rd_gnt0_e1", 0, obs[0].gnt0, 1'b1);
        cmp("rd_ram_rd_e1", 0, obs[0].ram_rd, 1'b1);
        cmp("rd_ram_addr_e1", 0, obs[0].ram_addr, 16'h0010);
        stim[0].req0 = 1'b0;
        step();
        cmp("rd_done0_e2", 0, obs[0].done0, 1'b1);
        cmp("rd_ram_rd_e2", 0, obs[0].ram_rd, 1'b0);
        cmp("rd_rdata0", 0, obs[0].rdata0, 16'hBEEF);
        step();
        cmp("rd_gnt0_e3", 0, obs[0].gnt0, 1'b0);
        cmp("rd_state_e3", 0, obs[0].stateout, 2'd0);

        // Write with three wait cycles on port 1.
        stim[1].req1 = 1'b1; stim[1].we1 = 1'b1; stim[1].addr1 = 16'h0200; stim[1].wdata1 = 16'h1234;
        wr_n = 0; done_at = 0;
        for (int e = 1; e <= 8; e++) begin
            step();
            if (e == 1) stim[1].req1 = 1'b0;
            if (obs[1].ram_wr) begin
                wr_n++;
                cmp("wr_addr", 1, obs[1].ram_addr, 16'h0200);
                cmp("wr_wdata", 1, obs[1].ram_wdata, 16'h1234);
            end
            if (obs[1].done1 && done_at == 0) done_at = e;
        end
        cmp("wr_cycles", 1, 16'(wr_n), 16'd3);
        cmp("wr_done_edge", 1, 16'(done_at), 16'd4);
        cmp("wr_rdata1", 1, obs[1].rdata1, 16'h0000);

        // Changing the request after grant has no effect.
        stim[1].req0 = 1'b1; stim[1].we0 = 1'b0; stim[1].addr0 = 16'h0040;
        step();
        stim[1].addr0 = 16'hFFFF; stim[1].req0 = 1'b0;
        done_seen = 1'b0;
        for (int e = 2; e <= 6; e++) begin
            step();
            if (obs[1].ram_rd) cmp("chg_ram_addr", 1, obs[1].ram_addr, 16'h0040);
            if (obs[1].done0) done_seen = 1'b1;
        end
        cmp("chg_done0", 1, done_seen, 1'b1);
        cmp("chg_rdata0", 1, obs[1].rdata0, 16'h1A5A);

        // Contention from reset: grants must alternate starting with port 0.
        async_reset();
        stim[1].req0 = 1'b1; stim[1].req1 = 1'b1; stim[1].we0 = 1'b0; stim[1].we1 = 1'b0;
        stim[1].addr0 = 16'h0010; stim[1].addr1 = 16'h0033;
        step();
        reset = 1'b0;
        n_gnt = 0;
        prev_st = obs[1].stateout;
        for (int e = 0; e < 40 && n_gnt < 4; e++) begin
            step();
            if (obs[1].stateout == 2'd1 && prev_st == 2'd0) begin
                gseq[n_gnt] = obs[1].gnt1 ? 1 : 0;
                n_gnt++;
            end
            prev_st = obs[1].stateout;
        end
        cmp("cont_grants", 1, 16'(n_gnt), 16'd4);
        for (int i = 0; i < n_gnt; i++) cmp("cont_order", 1, 16'(gseq[i]), 16'(i % 2));

        // Reset in the second access cycle abandons the transaction.
        stim[1].req0 = 1'b0; stim[1].req1 = 1'b0;
        for (int e = 0; e < 10 && obs[1].busy; e++) step();
        cmp("mid_idle", 1, obs[1].busy, 1'b0);
        stim[1].req0 = 1'b1; stim[1].we0 = 1'b1; stim[1].addr0 = 16'h0077; stim[1].wdata0 = 16'h5555;
        step();
        step();
        cmp("mid_ram_wr_pre", 1, obs[1].ram_wr, 1'b1);
        async_reset();
        cmp("mid_gnt0", 1, obs[1].gnt0, 1'b0);
        cmp("mid_ram_wr", 1, obs[1].ram_wr, 1'b0);
        cmp("mid_busy", 1, obs[1].busy, 1'b0);
        cmp("mid_ram_addr", 1, obs[1].ram_addr, 16'h0000);
        step();
        cmp("mid_done0", 1, obs[1].done0, 1'b0);
        reset = 1'b0;
        step();
        cmp("post_gnt0", 1, obs[1].gnt0, 1'b1);
        cmp("post_state", 1, obs[1].stateout, 2'd1);
        stim[1].req0 = 1'b0;
        for (int e = 0; e < 5; e++) step();

        // Port 1 held high alone: one transaction every WAIT_CYCLES+2 cycles.
        stim[1].req1 = 1'b1; stim[1].we1 = 1'b0; stim[1].addr1 = 16'h0123;
        n_done = 0; prev_done = -1;
        for (int e = 0; e < 40; e++) begin
            step();
            if (obs[1].gnt0) cmp("b2b_gnt0", 1, obs[1].gnt0, 1'b0);
            if (obs[1].done1) begin
                if (prev_done >= 0) cmp("b2b_period", 1, 16'(e - prev_done), 16'd5);
                prev_done = e;
                n_done++;
            end
        end
        cmp("b2b_count", 1, 16'(n_done >= 7), 1'b1);
        stim[1] = '0;
        for (int e = 0; e < 6; e++) step();

        // Randomized traffic on both instances.
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 2; k++) begin
                stim[k].req0   = ($urandom % 3) != 0;
                stim[k].req1   = ($urandom % 3) != 0;
                stim[k].we0    = $urandom % 2;
                stim[k].we1    = $urandom % 2;
                stim[k].addr0  = 16'($urandom);
                stim[k].addr1  = ($urandom % 4 == 0) ? 16'h0010 : 16'($urandom);
                stim[k].wdata0 = 16'($urandom);
                stim[k].wdata1 = 16'($urandom);
            end
            if ($urandom % 300 == 0) begin
                async_reset();
                step();
                reset = 1'b0;
            end else begin
                step();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
